// File: rtl/fw_cmd_decoder.sv
// fw_cmd_decoder
// Command front-end for the pixel test firmware. Accepts 32-bit command
// words, checks device_id, decodes op_code, holds the static and execute
// configuration registers, issues one-cycle strobes and keeps the sticky
// firmware status word.
//
// Optional build macro: CMD_DECODER_ABORT_EN
//   When defined, words are accepted during WAIT_DONE. A W_RST_FW aborts the
//   running test (exec_abort). Any other word is dropped and flagged in
//   status[19].
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a command word
// DECODE    | registered word is decoded, results land on the next edge
// WAIT_DONE | test running, waiting for its test_done pulse or timeout
module fw_cmd_decoder #(
    parameter logic [3:0]           FIRMWARE_ID = 4'h1,
    parameter int                   TIMEOUT_W   = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 20'hFFFFF
) (
    input  logic        fw_axi_clk,
    input  logic        fw_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_word,
    output logic [23:0] w_cfg_static_0_reg,
    output logic [23:0] w_cfg_static_1_reg,
    output logic [23:0] w_execute_cfg,
    output logic        fw_rst_strb,
    output logic        exec_start,
    input  logic [3:0]  test_done,
    output logic        rd_strb,
    output logic [3:0]  rd_sel,
`ifdef CMD_DECODER_ABORT_EN
    output logic        exec_abort,
`endif
    output logic [31:0] status
);

    localparam logic [3:0] OP_NOOP              = 4'h0;
    localparam logic [3:0] OP_W_RST_FW          = 4'h1;
    localparam logic [3:0] OP_W_CFG_STATIC_0    = 4'h2;
    localparam logic [3:0] OP_R_CFG_STATIC_0    = 4'h3;
    localparam logic [3:0] OP_W_CFG_STATIC_1    = 4'h4;
    localparam logic [3:0] OP_R_CFG_STATIC_1    = 4'h5;
    localparam logic [3:0] OP_W_CFG_ARRAY_0     = 4'h6;
    localparam logic [3:0] OP_R_CFG_ARRAY_0     = 4'h7;
    localparam logic [3:0] OP_W_CFG_ARRAY_1     = 4'h8;
    localparam logic [3:0] OP_R_CFG_ARRAY_1     = 4'h9;
    localparam logic [3:0] OP_W_CFG_ARRAY_2     = 4'hA;
    localparam logic [3:0] OP_R_CFG_ARRAY_2     = 4'hB;
    localparam logic [3:0] OP_R_DATA_ARRAY_0    = 4'hC;
    localparam logic [3:0] OP_R_DATA_ARRAY_1    = 4'hD;
    localparam logic [3:0] OP_W_STATUS_FW_CLEAR = 4'hE;
    localparam logic [3:0] OP_W_EXECUTE         = 4'hF;

    // status bits that can ever be set; [29:19] stay 0 (bit 19 only with abort)
`ifdef CMD_DECODER_ABORT_EN
    localparam logic [31:0] STATUS_MASK = 32'hC00F_FFFF;
`else
    localparam logic [31:0] STATUS_MASK = 32'hC007_FFFF;
`endif

    localparam logic [TIMEOUT_W-1:0] TMO_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [31:0]          cmd_q, cmd_q_nxt;
    logic [3:0]           test_sel, test_sel_nxt;
    logic [TIMEOUT_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [23:0]          cfg_s0_nxt, cfg_s1_nxt, exec_cfg_nxt;
    logic [3:0]           rd_sel_nxt;
    logic                 rst_strb_nxt, start_nxt, rd_strb_nxt;
    logic [31:0]          status_set, status_nxt;
    logic                 status_clr;
    logic                 accept;
    logic [3:0]           cmd_id, cmd_op;
    logic [23:0]          cmd_body;
    logic [3:0]           done_hit;
`ifdef CMD_DECODER_ABORT_EN
    logic                 abort_nxt;
`endif

    assign cmd_id   = cmd_q[31:28];
    assign cmd_op   = cmd_q[27:24];
    assign cmd_body = cmd_q[23:0];
    assign done_hit = test_done & test_sel;

    // ready is a pure function of state so reset raises it without a clock
`ifdef CMD_DECODER_ABORT_EN
    assign cmd_ready = (state == IDLE) || (state == WAIT_DONE);
`else
    assign cmd_ready = (state == IDLE);
`endif
    assign accept = cmd_valid && cmd_ready;

    // state register
    always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
        if (fw_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state, register loads, strobes and status updates
    always_comb begin
        state_nxt    = state;
        cmd_q_nxt    = cmd_q;
        test_sel_nxt = test_sel;
        tmo_cnt_nxt  = tmo_cnt;
        cfg_s0_nxt   = w_cfg_static_0_reg;
        cfg_s1_nxt   = w_cfg_static_1_reg;
        exec_cfg_nxt = w_execute_cfg;
        rd_sel_nxt   = rd_sel;
        rst_strb_nxt = 1'b0;
        start_nxt    = 1'b0;
        rd_strb_nxt  = 1'b0;
        status_set   = 32'h0;
        status_clr   = 1'b0;
`ifdef CMD_DECODER_ABORT_EN
        abort_nxt    = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (accept) begin
                    cmd_q_nxt = cmd_word;
                    state_nxt = DECODE;
                end
            end

            DECODE: begin
                state_nxt = IDLE;
                if (cmd_id != FIRMWARE_ID) begin
                    status_set[18] = 1'b1;
                end else begin
                    case (cmd_op)
                        OP_NOOP: begin
                        end
                        OP_W_RST_FW: begin
                            rst_strb_nxt  = 1'b1;
                            cfg_s0_nxt    = 24'h0;
                            cfg_s1_nxt    = 24'h0;
                            exec_cfg_nxt  = 24'h0;
                            status_clr    = 1'b1;
                            status_set[0] = 1'b1;
                        end
                        OP_W_CFG_STATIC_0: begin
                            cfg_s0_nxt    = cmd_body;
                            status_set[1] = 1'b1;
                        end
                        OP_W_CFG_STATIC_1: begin
                            cfg_s1_nxt    = cmd_body;
                            status_set[3] = 1'b1;
                        end
                        OP_R_CFG_STATIC_0: begin
                            rd_strb_nxt   = 1'b1;
                            rd_sel_nxt    = cmd_op;
                            status_set[2] = 1'b1;
                        end
                        OP_R_CFG_STATIC_1: begin
                            rd_strb_nxt   = 1'b1;
                            rd_sel_nxt    = cmd_op;
                            status_set[4] = 1'b1;
                        end
                        OP_R_CFG_ARRAY_0: begin
                            rd_strb_nxt   = 1'b1;
                            rd_sel_nxt    = cmd_op;
                            status_set[6] = 1'b1;
                        end
                        OP_R_CFG_ARRAY_1: begin
                            rd_strb_nxt   = 1'b1;
                            rd_sel_nxt    = cmd_op;
                            status_set[8] = 1'b1;
                        end
                        OP_R_CFG_ARRAY_2: begin
                            rd_strb_nxt    = 1'b1;
                            rd_sel_nxt     = cmd_op;
                            status_set[10] = 1'b1;
                        end
                        OP_R_DATA_ARRAY_0: begin
                            rd_strb_nxt    = 1'b1;
                            rd_sel_nxt     = cmd_op;
                            status_set[11] = 1'b1;
                        end
                        OP_R_DATA_ARRAY_1: begin
                            rd_strb_nxt    = 1'b1;
                            rd_sel_nxt     = cmd_op;
                            status_set[12] = 1'b1;
                        end
                        OP_W_CFG_ARRAY_0: status_set[5] = 1'b1;
                        OP_W_CFG_ARRAY_1: status_set[7] = 1'b1;
                        OP_W_CFG_ARRAY_2: status_set[9] = 1'b1;
                        OP_W_STATUS_FW_CLEAR: begin
                            status_clr = 1'b1;
                        end
                        OP_W_EXECUTE: begin
                            exec_cfg_nxt   = cmd_body;
                            test_sel_nxt   = cmd_body[17:14];
                            status_set[13] = 1'b1;
                            case (cmd_body[17:14])
                                4'h1, 4'h2, 4'h4, 4'h8: begin
                                    start_nxt   = 1'b1;
                                    tmo_cnt_nxt = '0;
                                    state_nxt   = WAIT_DONE;
                                end
                                default: status_set[31] = 1'b1;
                            endcase
                        end
                        default: begin
                        end
                    endcase
                end
            end

            WAIT_DONE: begin
                tmo_cnt_nxt = tmo_cnt + TMO_ONE;
                // a done pulse wins over a timeout landing in the same cycle
                if (|done_hit) begin
                    status_set[17:14] = done_hit;
                    state_nxt         = IDLE;
                end else if (tmo_cnt == TIMEOUT_MAX) begin
                    status_set[30] = 1'b1;
                    state_nxt      = IDLE;
                end
`ifdef CMD_DECODER_ABORT_EN
                // words arriving mid-test are acted on directly: reset aborts,
                // anything else is dropped and flagged
                if (accept) begin
                    if (cmd_word[31:28] == FIRMWARE_ID && cmd_word[27:24] == OP_W_RST_FW) begin
                        abort_nxt    = 1'b1;
                        rst_strb_nxt = 1'b1;
                        cfg_s0_nxt   = 24'h0;
                        cfg_s1_nxt   = 24'h0;
                        exec_cfg_nxt = 24'h0;
                        status_clr   = 1'b1;
                        status_set   = 32'h1;
                        state_nxt    = IDLE;
                    end else begin
                        status_set[19] = 1'b1;
                    end
                end
`endif
            end

            default: state_nxt = IDLE;
        endcase

        status_nxt = ((status_clr ? 32'h0 : status) | status_set) & STATUS_MASK;
    end

    // datapath and output registers
    always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
        if (fw_rst) begin
            cmd_q              <= 32'h0;
            test_sel           <= 4'h0;
            tmo_cnt            <= '0;
            w_cfg_static_0_reg <= 24'h0;
            w_cfg_static_1_reg <= 24'h0;
            w_execute_cfg      <= 24'h0;
            rd_sel             <= 4'h0;
            fw_rst_strb        <= 1'b0;
            exec_start         <= 1'b0;
            rd_strb            <= 1'b0;
            status             <= 32'h0;
        end else begin
            cmd_q              <= cmd_q_nxt;
            test_sel           <= test_sel_nxt;
            tmo_cnt            <= tmo_cnt_nxt;
            w_cfg_static_0_reg <= cfg_s0_nxt;
            w_cfg_static_1_reg <= cfg_s1_nxt;
            w_execute_cfg      <= exec_cfg_nxt;
            rd_sel             <= rd_sel_nxt;
            fw_rst_strb        <= rst_strb_nxt;
            exec_start         <= start_nxt;
            rd_strb            <= rd_strb_nxt;
            status             <= status_nxt;
        end
    end

`ifdef CMD_DECODER_ABORT_EN
    // abort strobe register
    always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
        if (fw_rst) begin
            exec_abort <= 1'b0;
        end else begin
            exec_abort <= abort_nxt;
        end
    end
`endif

endmodule
